// File: rtl/romulus_round_sched_pkg.sv
// Shared configuration, state encoding and round-constant step for the
// Romulus Skinny-128-384+ round scheduler.
package romulus_round_sched_pkg;

    localparam int unsigned DEF_ROUNDS       = 40;
    localparam int unsigned DEF_RNDS_PER_CLK = 1;
    localparam int unsigned DEF_CNTW         = 6;
    localparam int unsigned RC_W             = 6;

    localparam logic [RC_W-1:0] RC_SEED = 6'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ROUND = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Control triple shared by the X/Y/Z/S registers.
    typedef struct packed {
        logic rst;
        logic enc;
        logic en;
    } reg_ctrl_t;

    function automatic logic [RC_W-1:0] rc_step(input logic [RC_W-1:0] rc);
        return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
    endfunction

endpackage

// File: rtl/romulus_round_sched_rc_lfsr.sv
// Round-constant LFSR: registered state plus RPC unrolled steps that produce
// this cycle's constants, earliest round in the most-significant slice.
module romulus_rc_lfsr
    import romulus_round_sched_pkg::*;
#(
    parameter int unsigned RPC = DEF_RNDS_PER_CLK,
    parameter int unsigned CW  = DEF_CNTW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            init,
    input  logic            adv,
    output logic [CW*RPC-1:0] constant
);

    logic [RC_W-1:0] rc_q;
    logic [RC_W-1:0] rc_d;
    logic [RC_W-1:0] rc_walk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rc_q <= RC_SEED;
        end else begin
            rc_q <= rc_d;
        end
    end

    always_comb begin
        rc_walk  = rc_q;
        constant = '0;
        for (int unsigned i = 0; i < RPC; i++) begin
            rc_walk = rc_step(rc_walk);
            constant[CW*(RPC-1-i) +: CW] = CW'(rc_walk);
        end
        rc_d = rc_q;
        if (init) begin
            rc_d = RC_SEED;
        end else if (adv) begin
            rc_d = rc_walk;
        end
    end

endmodule

// File: rtl/romulus_round_sched.sv
// Round scheduler: after one start, drives the X/Y/Z/S register controls and
// round constants for ROUNDS/RNDS_PER_CLK cycles, then pulses done.
module romulus_round_sched
    import romulus_round_sched_pkg::*;
#(
    parameter int unsigned ROUNDS       = DEF_ROUNDS,
    parameter int unsigned RNDS_PER_CLK = DEF_RNDS_PER_CLK,
    parameter int unsigned CNTW         = DEF_CNTW
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         ready,
    input  logic                         hold,
    input  logic                         abort,
    output logic                         done,
    output logic                         busy,
    output logic                         xrst,
    output logic                         yrst,
    output logic                         zrst,
    output logic                         srst,
    output logic                         xenc,
    output logic                         yenc,
    output logic                         zenc,
    output logic                         senc,
    output logic                         xen,
    output logic                         yen,
    output logic                         zen,
    output logic                         sen,
    output logic [CNTW*RNDS_PER_CLK-1:0] constant
);

    localparam int unsigned NCYC  = ROUNDS / RNDS_PER_CLK;
    localparam int unsigned CNT_W = $clog2(NCYC + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCYC - 1);

    if ((ROUNDS % RNDS_PER_CLK) != 0) begin : g_bad_cfg
        $error("romulus_round_sched: ROUNDS must be a multiple of RNDS_PER_CLK");
    end

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    reg_ctrl_t        ctrl;
    logic             done_c;
    logic             lfsr_init;
    logic             lfsr_adv;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, register controls and LFSR sequencing; abort overrides all.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl      = '0;
        done_c    = 1'b0;
        lfsr_init = 1'b0;
        lfsr_adv  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                lfsr_init = 1'b1;
                if (start && !abort) begin
                    state_d = ST_ROUND;
                    cnt_d   = '0;
                end
            end
            ST_ROUND: begin
                ctrl.enc = 1'b1;
                if (abort) begin
                    state_d   = ST_IDLE;
                    lfsr_init = 1'b1;
                end else if (!hold) begin
                    ctrl.en  = 1'b1;
                    lfsr_adv = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                lfsr_init = 1'b1;
                done_c    = !abort;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                lfsr_init = 1'b1;
            end
        endcase
    end

    romulus_rc_lfsr #(
        .RPC (RNDS_PER_CLK),
        .CW  (CNTW)
    ) u_rc_lfsr (
        .clk      (clk),
        .rst      (rst),
        .init     (lfsr_init),
        .adv      (lfsr_adv),
        .constant (constant)
    );

    assign ready = (state_q == ST_IDLE);
    assign busy  = !ready;
    assign done  = done_c;

    assign xrst = ctrl.rst;
    assign yrst = ctrl.rst;
    assign zrst = ctrl.rst;
    assign srst = ctrl.rst;
    assign xenc = ctrl.enc;
    assign yenc = ctrl.enc;
    assign zenc = ctrl.enc;
    assign senc = ctrl.enc;
    assign xen  = ctrl.en;
    assign yen  = ctrl.en;
    assign zen  = ctrl.en;
    assign sen  = ctrl.en;

endmodule

// File: tb/tb_romulus_round_sched.sv
// Scoreboard bench for romulus_round_sched: two instances (1 and 4 rounds per
// clock) share stimulus and are checked against a round-index reference model.
module tb_romulus_round_sched;

    localparam int unsigned ROUNDS = 40;
    localparam int unsigned CW     = 6;
    localparam int unsigned RPC0   = 1;
    localparam int unsigned RPC1   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic hold = 1'b0;
    logic abort = 1'b0;

    logic ready_w [2];
    logic done_w  [2];
    logic busy_w  [2];
    logic xr [2], yr [2], zr [2], sr [2];
    logic xc [2], yc [2], zc [2], sc [2];
    logic xn [2], yn [2], zn [2], sn [2];
    logic [CW*RPC0-1:0] c0;
    logic [CW*RPC1-1:0] c1;

    always #5 clk = ~clk;

    romulus_round_sched #(.ROUNDS(ROUNDS), .RNDS_PER_CLK(RPC0), .CNTW(CW)) dut1 (
        .clk(clk), .rst(rst), .start(start), .ready(ready_w[0]), .hold(hold),
        .abort(abort), .done(done_w[0]), .busy(busy_w[0]),
        .xrst(xr[0]), .yrst(yr[0]), .zrst(zr[0]), .srst(sr[0]),
        .xenc(xc[0]), .yenc(yc[0]), .zenc(zc[0]), .senc(sc[0]),
        .xen(xn[0]), .yen(yn[0]), .zen(zn[0]), .sen(sn[0]),
        .constant(c0)
    );

    romulus_round_sched #(.ROUNDS(ROUNDS), .RNDS_PER_CLK(RPC1), .CNTW(CW)) dut4 (
        .clk(clk), .rst(rst), .start(start), .ready(ready_w[1]), .hold(hold),
        .abort(abort), .done(done_w[1]), .busy(busy_w[1]),
        .xrst(xr[1]), .yrst(yr[1]), .zrst(zr[1]), .srst(sr[1]),
        .xenc(xc[1]), .yenc(yc[1]), .zenc(zc[1]), .senc(sc[1]),
        .xen(xn[1]), .yen(yn[1]), .zen(zn[1]), .sen(sn[1]),
        .constant(c1)
    );

    typedef struct {
        bit          is_done;
        logic [47:0] cst;
    } ev_t;

    ev_t q0 [$];
    ev_t q1 [$];

    int unsigned rpc  [2] = '{RPC0, RPC1};
    int unsigned ncyc [2] = '{ROUNDS / RPC0, ROUNDS / RPC1};
    logic [5:0]  rc_tab [64];

    // Reference model: phase 0 idle, 1 rounds, 2 done; rnd = rounds-cycles retired.
    int          phase [2];
    int          rnd   [2];
    logic        exp_ready [2];
    logic [47:0] exp_const [2];
    int          en_cnt [2];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [47:0] pack(input int k, input int r);
        logic [47:0] v = '0;
        for (int j = 0; j < int'(rpc[k]); j++) begin
            v = (v << 6) | 48'(rc_tab[r * int'(rpc[k]) + j]);
        end
        return v;
    endfunction

    task automatic push_ev(input int k, input bit d, input logic [47:0] c);
        ev_t e;
        e.is_done = d;
        e.cst     = c;
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Apply this cycle's inputs and predict what each DUT shows during it.
    task automatic step(input bit s, input bit h, input bit a);
        start = s;
        hold  = h;
        abort = a;
        for (int k = 0; k < 2; k++) begin
            exp_ready[k] = (phase[k] == 0);
            exp_const[k] = pack(k, (phase[k] == 0) ? 0 : rnd[k]);
            case (phase[k])
                0: if (s && !a) begin
                    phase[k] = 1;
                    rnd[k]   = 0;
                end
                1: if (a) begin
                    phase[k] = 0;
                end else if (!h) begin
                    push_ev(k, 1'b0, pack(k, rnd[k]));
                    rnd[k]++;
                    if (rnd[k] == int'(ncyc[k])) phase[k] = 2;
                end
                default: begin
                    if (!a) push_ev(k, 1'b1, '0);
                    phase[k] = 0;
                end
            endcase
        end
    endtask

    task automatic cycle(input bit s, input bit h, input bit a);
        @(posedge clk);
        #1;
        step(s, h, a);
    endtask

    task automatic reset_checks();
        check("rst_ready1", 48'(ready_w[0]), 48'd1);
        check("rst_ready4", 48'(ready_w[1]), 48'd1);
        check("rst_busy", 48'({busy_w[0], busy_w[1]}), 48'd0);
        check("rst_done", 48'({done_w[0], done_w[1]}), 48'd0);
        check("rst_en", 48'({sn[0], xn[0], sn[1], xn[1]}), 48'd0);
        check("rst_enc", 48'({sc[0], xc[0], sc[1], xc[1]}), 48'd0);
        check("rst_const1", 48'(c0), pack(0, 0));
        check("rst_const4", 48'(c1), pack(1, 0));
    endtask

    // Drop rst between edges, check outputs at once, release a cycle later.
    task automatic async_reset();
        @(posedge clk);
        #2;
        rst   = 1'b0;
        start = 1'b0;
        hold  = 1'b0;
        abort = 1'b0;
        #1;
        reset_checks();
        q0.delete();
        q1.delete();
        phase = '{0, 0};
        rnd   = '{0, 0};
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: per-cycle status checks; pops the scoreboard on sen or done.
    always @(negedge clk) begin
        logic [47:0] cv [2];
        ev_t e;
        bit  empty;
        cv[0] = 48'(c0);
        cv[1] = 48'(c1);
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                check("ready", 48'(ready_w[k]), 48'(exp_ready[k]));
                check("busy", 48'(busy_w[k]), 48'(!exp_ready[k]));
                check("constant", cv[k], exp_const[k]);
                check("ld_sel", 48'({xr[k], yr[k], zr[k], sr[k]}), 48'd0);
                check("en_uniform", 48'({xn[k], yn[k], zn[k]}), 48'({3{sn[k]}}));
                check("enc_uniform", 48'({xc[k], yc[k], zc[k]}), 48'({3{sc[k]}}));
                if (sn[k]) en_cnt[k]++;
                if (sn[k] || done_w[k]) begin
                    empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
                    if (empty) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_event inst%0d at %0t: sen=%b done=%b, none expected",
                                 k, $time, sn[k], done_w[k]);
                    end else begin
                        e = (k == 0) ? q0.pop_front() : q1.pop_front();
                        check("event_kind", 48'(done_w[k]), 48'(e.is_done));
                        if (!e.is_done) begin
                            check("round_const", cv[k], e.cst);
                            check("round_enc", 48'(sc[k]), 48'd1);
                        end else begin
                            check("done_en", 48'(sn[k]), 48'd0);
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [5:0] r = 6'h00;
        for (int i = 0; i < 64; i++) begin
            r         = {r[4:0], r[5] ^ r[4] ^ 1'b1};
            rc_tab[i] = r;
        end
        phase  = '{0, 0};
        rnd    = '{0, 0};
        en_cnt = '{0, 0};
        exp_ready = '{1'b1, 1'b1};
        exp_const = '{48'd0, 48'd0};

        #3;
        reset_checks();
        check("seq_first", 48'(rc_tab[0]), 48'h01);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);

        // Plain call.
        en_cnt = '{0, 0};
        cycle(1'b1, 1'b0, 1'b0);
        repeat (45) cycle(1'b0, 1'b0, 1'b0);
        check("sen_cycles1", 48'(en_cnt[0]), 48'd40);
        check("sen_cycles4", 48'(en_cnt[1]), 48'd10);

        // Hold for three cycles after round 5.
        en_cnt = '{0, 0};
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10 && !(phase[0] == 1 && rnd[0] == 5); i++) cycle(1'b0, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        repeat (45) cycle(1'b0, 1'b0, 1'b0);
        check("hold_sen_cycles", 48'(en_cnt[0]), 48'd40);

        // Abort at round 20, then restart.
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30 && !(phase[0] == 1 && rnd[0] == 20); i++) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        repeat (45) cycle(1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-call, then a full call.
        cycle(1'b1, 1'b0, 1'b0);
        repeat (12) cycle(1'b0, 1'b0, 1'b0);
        async_reset();
        en_cnt = '{0, 0};
        cycle(1'b1, 1'b0, 1'b0);
        repeat (45) cycle(1'b0, 1'b0, 1'b0);
        check("post_reset_sen", 48'(en_cnt[0]), 48'd40);

        // start held high: back-to-back calls.
        repeat (100) cycle(1'b1, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                async_reset();
            end else begin
                cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 39) == 0);
            end
        end

        repeat (50) cycle(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("drain1", 48'(q0.size()), 48'd0);
        check("drain4", 48'(q1.size()), 48'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
